// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: pin-side and game-side signals of the 4x4 keypad scanner.
//   row       - row drive, active-low, one row low at a time
//   col       - column sense, active-low, pulled up, asynchronous
//   key       - debounced 16-bit bitmap, bit = row*4 + col, 1 = pressed
//   key_press - one-cycle pulse on a clean single-key press
//   key_code  - index of the most recent key_press key
//   key_multi - high while key has two or more bits set
// master: the scanner; slave: keypad pins / game core.
interface keypad_scanner_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key;
  logic        key_press;
  logic [3:0]  key_code;
  logic        key_multi;

  modport master (
    output row, key, key_press, key_code, key_multi,
    input  col
  );

  modport slave (
    input  row, key, key_press, key_code, key_multi,
    output col
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one row at a time,
// debounces whole 16-bit frames and publishes a stable bitmap together with
// a single-press event, its key index and a multi-key flag.
// Ports:
//   clk - system clock
//   rst - asynchronous, active-high reset
//   kp  - keypad_scanner_if.master (row/col pins, key/key_press/key_code/key_multi)
//
// state | meaning
// ------+-------------------------------------------
// ROW0  | row = 1110, scanning keys 0..3
// ROW1  | row = 1101, scanning keys 4..7
// ROW2  | row = 1011, scanning keys 8..11
// ROW3  | row = 0111, scanning keys 12..15; its sample ends the frame
module keypad_scanner #(
  parameter int SCAN_DIV        = 10_000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic              clk,
  input  logic              rst,
  keypad_scanner_if.master  kp
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_PRE    = CW'(DEBOUNCE_FRAMES - 1);

  typedef enum logic [1:0] {ROW0 = 2'd0, ROW1 = 2'd1, ROW2 = 2'd2, ROW3 = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    col_s1_q, cs_q;
  logic [15:0]   raw_q, raw_d;
  logic          frame_end_q, frame_end_d;
  logic [15:0]   cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   key_q, key_d;
  logic          key_press_q, key_press_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_multi_q, key_multi_d;
  logic          dwell_last;

  function automatic logic is_onehot(input logic [15:0] v);
    return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
  endfunction

  function automatic logic [3:0] bit_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  assign dwell_last = (dwell_q == DWELL_LAST);

  // Row FSM and dwell counter
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q + DW'(1);
    if (dwell_last) begin
      dwell_d = '0;
      case (state_q)
        ROW0:    state_d = ROW1;
        ROW1:    state_d = ROW2;
        ROW2:    state_d = ROW3;
        default: state_d = ROW0;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ROW0:    kp.row = 4'b1110;
      ROW1:    kp.row = 4'b1101;
      ROW2:    kp.row = 4'b1011;
      default: kp.row = 4'b0111;
    endcase
  end

  // Late-dwell sampling; the ROW3 sample completes the frame, which the
  // debouncer consumes one cycle later once raw_q holds all 16 bits.
  always_comb begin
    raw_d       = raw_q;
    frame_end_d = 1'b0;
    if (dwell_last) begin
      case (state_q)
        ROW0:    raw_d[3:0]   = ~cs_q;
        ROW1:    raw_d[7:4]   = ~cs_q;
        ROW2:    raw_d[11:8]  = ~cs_q;
        default: begin
          raw_d[15:12] = ~cs_q;
          frame_end_d  = 1'b1;
        end
      endcase
    end
  end

  // Frame debouncer and event generation
  always_comb begin
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    key_press_d = 1'b0;
    key_code_d  = key_code_q;
    key_multi_d = key_multi_q;
    if (frame_end_q) begin
      if (raw_q != cand_q) begin
        cand_d = raw_q;
        cnt_d  = CW'(1);
      end else if (cnt_q < CNT_FULL) begin
        cnt_d = cnt_q + CW'(1);
        // Only the step into the full count may update key, so a long
        // stable run never re-fires.
        if ((cnt_q == CNT_PRE) && (cand_q != key_q)) begin
          key_d       = cand_q;
          key_multi_d = ($countones(cand_q) >= 2);
          if ((key_q == 16'd0) && is_onehot(cand_q)) begin
            key_press_d = 1'b1;
            key_code_d  = bit_index(cand_q);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ROW0;
      dwell_q     <= '0;
      col_s1_q    <= 4'hF;
      cs_q        <= 4'hF;
      raw_q       <= '0;
      frame_end_q <= 1'b0;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      key_press_q <= 1'b0;
      key_code_q  <= '0;
      key_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      col_s1_q    <= kp.col;
      cs_q        <= col_s1_q;
      raw_q       <= raw_d;
      frame_end_q <= frame_end_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      key_press_q <= key_press_d;
      key_code_q  <= key_code_d;
      key_multi_q <= key_multi_d;
    end
  end

  assign kp.key       = key_q;
  assign kp.key_press = key_press_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_multi = key_multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: frame-level reference model of keypad_scanner with a
// behavioural keypad matrix; directed scenarios followed by random key runs.
module tb_keypad_scanner;
  localparam int SD = 8;
  localparam int DF = 3;
  localparam int FRAME = 4 * SD;

  logic clk;
  logic rst;
  logic [15:0] pressed;

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its column to its row.
  always_comb begin
    kif.col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.row[r] && pressed[r*4+c]) kif.col[c] = 1'b0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Frame-level model
  logic [15:0] m_key, m_prev, m_new;
  logic [3:0]  m_code;
  int          m_run;
  bit          m_pend;

  task automatic model_reset();
    m_key = 0; m_prev = 0; m_new = 0; m_code = 0; m_run = 0; m_pend = 0;
  endtask

  task automatic model_frame(input logic [15:0] m);
    if (m == m_prev) m_run++;
    else m_run = 1;
    m_prev = m;
    if (m_run == DF && m != m_key) begin
      m_pend = 1;
      m_new  = m;
    end
  endtask

  // Holds mask for n cycles starting at a frame boundary; a complete frame
  // is fed to the model.
  task automatic run_frame(input logic [15:0] mask, input int n);
    bit exp_press;
    pressed = mask;
    for (int j = 1; j <= n; j++) begin
      @(posedge clk);
      #1;
      exp_press = 0;
      if (j == 1 && m_pend) begin
        if (m_key == 0 && $countones(m_new) == 1) begin
          exp_press = 1;
          for (int i = 0; i < 16; i++) if (m_new[i]) m_code = 4'(i);
        end
        m_key  = m_new;
        m_pend = 0;
      end
      chk("row", 16'(kif.row), 16'(4'hF & ~(4'b1 << ((j % FRAME) / SD))));
      chk("key", kif.key, m_key);
      chk("key_press", 16'(kif.key_press), 16'(exp_press));
      chk("key_code", 16'(kif.key_code), 16'(m_code));
      chk("key_multi", 16'(kif.key_multi), 16'($countones(m_key) >= 2));
    end
    if (n == FRAME) model_frame(mask);
  endtask

  task automatic frames(input logic [15:0] mask, input int k);
    for (int i = 0; i < k; i++) run_frame(mask, FRAME);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_row", 16'(kif.row), 16'h000E);
    chk("rst_key", kif.key, 16'h0000);
    chk("rst_press", 16'(kif.key_press), 16'h0000);
    chk("rst_code", 16'(kif.key_code), 16'h0000);
    chk("rst_multi", 16'(kif.key_multi), 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [15:0] rmask;

  initial begin
    rst = 1'b1;
    pressed = 16'h0;
    model_reset();
    do_reset();

    // reset and scan order, idle keypad
    frames(16'h0000, 2);
    // single press of key 6
    frames(16'h0040, 4);
    chk("s2_key", kif.key, 16'h0040);
    chk("s2_code", 16'(kif.key_code), 16'h0006);
    // release
    frames(16'h0000, 4);
    chk("s5_key", kif.key, 16'h0000);
    chk("s5_code", 16'(kif.key_code), 16'h0006);
    // bounce
    frames(16'h0040, 1); frames(16'h0000, 1);
    frames(16'h0040, 1); frames(16'h0000, 1);
    frames(16'h0040, 4);
    frames(16'h0000, 4);
    // multi-key
    frames(16'h8001, 4);
    chk("s4_key", kif.key, 16'h8001);
    chk("s4_multi", 16'(kif.key_multi), 16'h0001);
    chk("s4_code", 16'(kif.key_code), 16'h0006);
    frames(16'h0000, 4);
    // reset mid-frame while key 6 is held
    frames(16'h0040, 4);
    run_frame(16'h0040, 13);
    do_reset();
    frames(16'h0040, 4);
    chk("s6_key", kif.key, 16'h0040);
    frames(16'h0000, 4);

    // random runs
    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 3))
        0:       rmask = 16'h0000;
        1, 2:    begin rmask = 16'h0; rmask[$urandom_range(0, 15)] = 1'b1; end
        default: begin
          rmask = 16'h0;
          rmask[$urandom_range(0, 15)] = 1'b1;
          rmask[$urandom_range(0, 15)] = 1'b1;
        end
      endcase
      frames(rmask, $urandom_range(1, 4));
    end
    frames(16'h0000, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 4×4 matrix keypad that supplies the game's 16-bit key bitmap. It drives one keypad row low at a time and samples the four column lines. Each full scan frame is debounced, and a stable bitmap is published on `key`, with bit index = row·4 + col. It sits between the board keypad pins and the game core. It also provides a single-press event, the index of that key, and a multi-key flag.

## Interface
Parameters:
- `SCAN_DIV`, default 10_000: clocks spent on each row (1 ms at 10 MHz); must be ≥ 4.
- `DEBOUNCE_FRAMES`, default 4: number of consecutive identical frames needed to update `key`; must be ≥ 2.

Ports:
- `clk`  in  1  system clock (10 MHz).
- `rst`  in  1  asynchronous, active-high reset.
- `row`  out  4  row drive, active-low; exactly one bit is low at any time.
- `col`  in  4  column sense, active-low; externally pulled up and asynchronous to `clk`.
- `key`  out  16  debounced bitmap; 1 = pressed.
- `key_press`  out  1  one-cycle pulse on a clean single-key press.
- `key_code`  out  4  index of the most recent `key_press` key; held between events.
- `key_multi`  out  1  high while `key` has two or more bits set.

## Operation
- **Synchronizer:** `col` passes through a 2-flop synchronizer; `cs` is the synchronized value.
- **Row FSM:** four states, ROW0 to ROW3, in that order, then wrapping back to ROW0.
  - `row` encoding: ROW0 = 1110, ROW1 = 1101, ROW2 = 1011, ROW3 = 0111.
  - A dwell counter runs 0 to `SCAN_DIV`−1 in each state and moves to the next state on the last count.
- **Sampling:** on dwell count `SCAN_DIV`−1 of row r, capture `raw[r*4+c] <= ~cs[c]` for c = 0..3.
  - Sampling this late leaves settling time plus synchronizer delay.
- **Frame end:** the sample taken in ROW3 completes a frame.
  - The debounce logic sees the complete 16-bit frame, including the ROW3 bits just sampled, on the following cycle.
- **Debounce, on each frame end:**
  - If frame ≠ `cand`: `cand <= frame`, `cnt <= 1`.
  - Otherwise `cnt` increments, saturating at `DEBOUNCE_FRAMES`.
  - When `cnt` reaches `DEBOUNCE_FRAMES` (the transition only) and `cand` ≠ `key`: `key <= cand`.
- **Press event:** registered in the same cycle that `key` updates.
  - `key_press` = 1 iff the old `key` = 0 and the new `key` has exactly one bit set.
  - In that case `key_code <= ` index of that bit.
  - All other transitions (multi-key, release, change between pressed sets) produce no pulse and leave `key_code` unchanged.
- **Multi-key flag:** `key_multi` is registered alongside `key` and equals popcount(new `key`) ≥ 2.
- **No ghosting suppression:** three-key ghost patterns are reported as scanned.

## Timing
- **Reset values (asynchronous, immediate):**
  - `row` = 1110; dwell = 0.
  - `raw`, `cand` and `key` = 0; `cnt` = 0.
  - `key_press` = 0, `key_code` = 0, `key_multi` = 0.
- **Frame period:** 4·`SCAN_DIV` clocks.
- **Sample timing:** the sample of row r occurs `SCAN_DIV`−1 clocks after the `row` change. A `col` edge must precede that sample by 2 clocks to be captured.
- **Press latency:** from a stable `col` level to the `key` update is between (`DEBOUNCE_FRAMES`−1)·4·`SCAN_DIV` and `DEBOUNCE_FRAMES`·4·`SCAN_DIV`, plus 4 clocks.
- **Output alignment:** `key`, `key_press`, `key_code` and `key_multi` change on the same edge. `key_press` is high for exactly 1 clock.
- **Bounce:** any frame differing from `cand` restarts the count. `key` never takes an intermediate value.
- **Release:** an all-zero frame held for `DEBOUNCE_FRAMES` frames gives `key` = 0 and `key_multi` = 0, with no pulse.
- **Reset mid-frame:** partial `raw` and the count are discarded. Scanning restarts at ROW0 dwell 0 on the first clock after `rst` falls.

## Test plan
All scenarios use `SCAN_DIV` = 8 and `DEBOUNCE_FRAMES` = 3, giving a frame of 32 clocks.
1. **Reset and scan order:** assert `rst`, release, no key pressed → `row` = 1110 immediately. Then 1101 after 8 clocks, 1011 at 16, 0111 at 24, and 1110 at 32. `key` = 0 and `key_press` = 0 throughout.
2. **Single press:** model key index 6 (row 1, col 2), so `col[2]` = 0 while `row[1]` = 0; hold it → `key` = 16'h0040 after 3 stable frames (within 96+4 clocks). `key_press` pulses once, `key_code` = 6, `key_multi` = 0.
3. **Bounce:** toggle key 6 on alternate frames for 4 frames, then hold it → `key` remains 0 until 3 consecutive identical frames, then 16'h0040 with one pulse.
4. **Multi-key:** press keys 0 and 15 together → `key` = 16'h8001, `key_multi` = 1, no `key_press`, and `key_code` unchanged.
5. **Release:** after scenario 2, release → `key` = 0 after 3 frames, no pulse, and `key_code` still 6.
6. **Reset mid-operation:** assert `rst` mid-frame while key 6 is held → `key` = 0 and `row` = 1110 at once. After release, `key` returns to 16'h0040 with a fresh `key_press`.
